// File: rtl/buzzer_scheduler.sv
// Buzzer scheduler: arbitrates alarm > chime > key demands and sequences tone on/off phases.
// Define BUZZER_SCHED_KEYCLICK_EN to compile in the key-click state.
module buzzer_scheduler #(
    parameter logic [23:0] HALF_CYCLES  = 24'd12000000,
    parameter logic [21:0] KEY_CYCLES   = 22'd2400000,
    parameter logic [6:0]  ALARM_HALVES = 7'd60
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       alarm_req,
    input  logic       alarm_ack,
    input  logic       chime_req,
    input  logic [3:0] chime_count,
    input  logic       key_req,
    output logic       tone_en,
    output logic [1:0] tone_sel,
    output logic       busy,
    output logic       alarm_active
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
`ifdef BUZZER_SCHED_KEYCLICK_EN
        KEY       = 3'd1,
`endif
        CHIME_ON  = 3'd2,
        CHIME_OFF = 3'd3,
        ALARM_ON  = 3'd4,
        ALARM_OFF = 3'd5
    } state_t;

    localparam logic [23:0] HALF_LAST = HALF_CYCLES - 24'd1;
    localparam logic [6:0]  AL_LAST   = ALARM_HALVES - 7'd1;
`ifdef BUZZER_SCHED_KEYCLICK_EN
    localparam logic [23:0] KEY_LAST  = {2'b00, KEY_CYCLES} - 24'd1;
`else
    logic key_unused;
    assign key_unused = key_req | (KEY_CYCLES == 22'd0);
`endif

    state_t      state, state_nx;
    logic [23:0] ph_cnt;
    logic [6:0]  al_cnt, al_cnt_nx;
    logic [3:0]  beep_left, beep_left_nx;
    logic [3:0]  pend_n, pend_n_nx;
    logic        pend, pend_nx;
    logic        armed, armed_nx;
    logic        tone_en_nx, busy_nx, alarm_active_nx;
    logic [1:0]  tone_sel_nx;

    logic       chime_hit, alarm_go, half_end, in_alarm;
    logic [3:0] chime_clamped;

    assign chime_hit     = chime_req && (chime_count != 4'd0);
    assign chime_clamped = (chime_count > 4'd12) ? 4'd12 : chime_count;
    assign alarm_go      = alarm_req && armed;
    assign half_end      = (ph_cnt == HALF_LAST);
    assign in_alarm      = (state == ALARM_ON) || (state == ALARM_OFF);

    always_comb begin
        state_nx     = state;
        al_cnt_nx    = al_cnt;
        beep_left_nx = beep_left;
        pend_nx      = pend;
        pend_n_nx    = pend_n;
        armed_nx     = armed;
        if (chime_hit) begin
            pend_nx   = 1'b1;
            pend_n_nx = chime_clamped;
        end
        // Alarm entry drops whatever chime was queued or playing, except a request in this very cycle.
        if (!in_alarm && alarm_go) begin
            state_nx  = ALARM_ON;
            al_cnt_nx = 7'd0;
            pend_nx   = chime_hit;
        end else begin
            case (state)
                IDLE: begin
                    if (chime_hit) begin
                        state_nx     = CHIME_ON;
                        beep_left_nx = chime_clamped;
                        pend_nx      = 1'b0;
                    end else if (pend) begin
                        state_nx     = CHIME_ON;
                        beep_left_nx = pend_n;
                        pend_nx      = 1'b0;
                    end
`ifdef BUZZER_SCHED_KEYCLICK_EN
                    else if (key_req) begin
                        state_nx = KEY;
                    end
`endif
                end
`ifdef BUZZER_SCHED_KEYCLICK_EN
                KEY: begin
                    if (ph_cnt == KEY_LAST) state_nx = IDLE;
                end
`endif
                CHIME_ON: begin
                    if (half_end) state_nx = CHIME_OFF;
                end
                CHIME_OFF: begin
                    if (half_end) begin
                        if (beep_left > 4'd1) begin
                            state_nx     = CHIME_ON;
                            beep_left_nx = beep_left - 4'd1;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end
                ALARM_ON, ALARM_OFF: begin
                    if (alarm_ack) begin
                        state_nx = IDLE;
                        armed_nx = 1'b0;
                    end else if (!alarm_req) begin
                        state_nx = IDLE;
                    end else if (half_end) begin
                        if (al_cnt == AL_LAST) begin
                            state_nx = IDLE;
                            armed_nx = 1'b0;
                        end else begin
                            state_nx  = (state == ALARM_ON) ? ALARM_OFF : ALARM_ON;
                            al_cnt_nx = al_cnt + 7'd1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        // Re-arming needs alarm_req to drop, so a held time-up cannot retrigger.
        if (!alarm_req) armed_nx = 1'b1;
    end

    always_comb begin
        tone_en_nx      = 1'b0;
        tone_sel_nx     = 2'd0;
        busy_nx         = (state_nx != IDLE);
        alarm_active_nx = (state_nx == ALARM_ON) || (state_nx == ALARM_OFF);
        case (state_nx)
`ifdef BUZZER_SCHED_KEYCLICK_EN
            KEY: begin
                tone_en_nx  = 1'b1;
                tone_sel_nx = 2'd3;
            end
`endif
            CHIME_ON: begin
                tone_en_nx  = 1'b1;
                tone_sel_nx = 2'd1;
            end
            ALARM_ON: begin
                tone_en_nx  = 1'b1;
                tone_sel_nx = 2'd2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            ph_cnt       <= 24'd0;
            al_cnt       <= 7'd0;
            beep_left    <= 4'd0;
            pend_n       <= 4'd0;
            pend         <= 1'b0;
            armed        <= 1'b1;
            tone_en      <= 1'b0;
            tone_sel     <= 2'd0;
            busy         <= 1'b0;
            alarm_active <= 1'b0;
        end else begin
            state     <= state_nx;
            al_cnt    <= al_cnt_nx;
            beep_left <= beep_left_nx;
            pend_n    <= pend_n_nx;
            pend      <= pend_nx;
            armed     <= armed_nx;
            if (state_nx != state) begin
                ph_cnt <= 24'd0;
            end else if (ph_cnt != 24'hFFFFFF) begin
                ph_cnt <= ph_cnt + 24'd1;
            end
            tone_en      <= tone_en_nx;
            tone_sel     <= tone_sel_nx;
            busy         <= busy_nx;
            alarm_active <= alarm_active_nx;
        end
    end

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Testbench for buzzer_scheduler: output segments (value, length) are scored against a queue
// of hand-computed expected segments filled by the stimulus process.
module tb_buzzer_scheduler;

    logic       CLK = 1'b0;
    logic       RST;
    logic       alarm_req, alarm_ack, chime_req, key_req;
    logic [3:0] chime_count;
    logic       tone_en, busy, alarm_active;
    logic [1:0] tone_sel;

    always #5 CLK = ~CLK;

    buzzer_scheduler #(
        .HALF_CYCLES (24'd10),
        .KEY_CYCLES  (22'd4),
        .ALARM_HALVES(7'd6)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .alarm_req   (alarm_req),
        .alarm_ack   (alarm_ack),
        .chime_req   (chime_req),
        .chime_count (chime_count),
        .key_req     (key_req),
        .tone_en     (tone_en),
        .tone_sel    (tone_sel),
        .busy        (busy),
        .alarm_active(alarm_active)
    );

    // Segment value packing: {tone_en, tone_sel, busy, alarm_active}
    localparam logic [4:0] V_IDLE   = 5'b00000;
    localparam logic [4:0] V_CH_ON  = 5'b10110;
    localparam logic [4:0] V_CH_OFF = 5'b00010;
    localparam logic [4:0] V_AL_ON  = 5'b11011;
    localparam logic [4:0] V_AL_OFF = 5'b00011;
    localparam logic [4:0] V_KEY    = 5'b11110;

    typedef struct {
        logic [4:0] val;
        int         len;
        int         tag;
    } seg_t;

    seg_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   next_tag = 0;
    logic mon_en = 1'b0;
    logic flush_req = 1'b0;
    logic flush_done = 1'b0;

    // Length 0 means the segment length is not checked (idle gaps between tests).
    task automatic push_seg(input logic [4:0] v, input int n);
        seg_t s;
        s.val = v;
        s.len = n;
        s.tag = next_tag;
        next_tag++;
        exp_q.push_back(s);
    endtask

    task automatic push_chime(input int beeps);
        for (int i = 0; i < beeps; i++) begin
            push_seg(V_CH_ON, 10);
            push_seg(V_CH_OFF, 10);
        end
    endtask

    task automatic check_output(input logic [4:0] v, input int n);
        seg_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL extra_segment got val=%b len=%0d want no segment", v, n);
        end else begin
            e = exp_q.pop_front();
            if (v !== e.val) begin
                errors++;
                $display("[TB] FAIL seg%0d_value got %b want %b", e.tag, v, e.val);
            end
            if (e.len != 0) begin
                checks++;
                if (n != e.len) begin
                    errors++;
                    $display("[TB] FAIL seg%0d_len got %0d want %0d (val %b)", e.tag, n, e.len, e.val);
                end
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] count);
        chime_count = count;
        chime_req   = 1'b1;
        tick(1);
        chime_req   = 1'b0;
    endtask

    task automatic key_pulse();
        key_req = 1'b1;
        tick(1);
        key_req = 1'b0;
    endtask

    // Monitor: closes a segment whenever the packed output value changes.
    initial begin : monitor
        logic [4:0] cur;
        logic [4:0] prev;
        int         len;
        wait (mon_en);
        @(negedge CLK);
        prev = {tone_en, tone_sel, busy, alarm_active};
        len  = 1;
        forever begin
            @(negedge CLK);
            cur = {tone_en, tone_sel, busy, alarm_active};
            if (flush_req && !flush_done) begin
                check_output(prev, len);
                flush_done = 1'b1;
                prev = cur;
                len  = 1;
            end else if (cur !== prev) begin
                check_output(prev, len);
                prev = cur;
                len  = 1;
            end else begin
                len++;
            end
        end
    end

    initial begin
        RST         = 1'b1;
        alarm_req   = 1'b0;
        alarm_ack   = 1'b0;
        chime_req   = 1'b0;
        key_req     = 1'b0;
        chime_count = 4'd0;
        tick(2);
        push_seg(V_IDLE, 0);
        mon_en = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(3);

        $display("[TB] chime of 3 from idle");
        push_chime(3);
        push_seg(V_IDLE, 0);
        apply_stimulus(4'd3);
        tick(65);

        $display("[TB] held alarm times out, no retrigger until re-raised");
        for (int i = 0; i < 3; i++) begin
            push_seg(V_AL_ON, 10);
            push_seg(V_AL_OFF, 10);
        end
        push_seg(V_IDLE, 0);
        push_seg(V_AL_ON, 3);
        push_seg(V_IDLE, 0);
        alarm_req = 1'b1;
        tick(80);
        alarm_req = 1'b0;
        tick(3);
        alarm_req = 1'b1;
        tick(3);
        alarm_req = 1'b0;
        tick(5);

        $display("[TB] alarm preempts chime of 12, chime dropped after ack");
        push_seg(V_CH_ON, 10);
        push_seg(V_CH_OFF, 10);
        push_seg(V_CH_ON, 5);
        push_seg(V_AL_ON, 10);
        push_seg(V_AL_OFF, 4);
        push_seg(V_IDLE, 0);
        apply_stimulus(4'd12);
        tick(24);
        alarm_req = 1'b1;
        tick(14);
        alarm_ack = 1'b1;
        tick(1);
        alarm_ack = 1'b0;
        tick(30);
        alarm_req = 1'b0;
        tick(3);

        $display("[TB] chime latched during alarm served after ack");
        push_seg(V_AL_ON, 6);
        push_seg(V_IDLE, 1);
        push_chime(2);
        push_seg(V_IDLE, 0);
        alarm_req = 1'b1;
        tick(3);
        apply_stimulus(4'd2);
        tick(2);
        alarm_ack = 1'b1;
        tick(1);
        alarm_ack = 1'b0;
        alarm_req = 1'b0;
        tick(45);

        $display("[TB] key click, key during chime, count 0 and count 15");
`ifdef BUZZER_SCHED_KEYCLICK_EN
        push_seg(V_KEY, 4);
        push_seg(V_IDLE, 0);
`endif
        key_pulse();
        tick(8);
        push_chime(1);
        push_seg(V_IDLE, 0);
        apply_stimulus(4'd1);
        tick(2);
        key_pulse();
        tick(25);
        apply_stimulus(4'd0);
        tick(5);
        push_chime(12);
        push_seg(V_IDLE, 0);
        apply_stimulus(4'd15);
        tick(245);

        $display("[TB] chime arriving during key click");
`ifdef BUZZER_SCHED_KEYCLICK_EN
        push_seg(V_KEY, 4);
        push_seg(V_IDLE, 1);
`endif
        push_chime(1);
        push_seg(V_IDLE, 0);
        key_pulse();
        tick(1);
        apply_stimulus(4'd1);
        tick(30);

        $display("[TB] reset during alarm with pending chime");
        push_seg(V_AL_ON, 4);
        push_seg(V_IDLE, 0);
        alarm_req = 1'b1;
        tick(2);
        apply_stimulus(4'd2);
        tick(1);
        RST       = 1'b1;
        alarm_req = 1'b0;
        tick(1);
        RST = 1'b0;
        tick(30);

        flush_req = 1'b1;
        for (int i = 0; i < 10 && !flush_done; i++) tick(1);
        if (!flush_done) begin
            checks++;
            errors++;
            $display("[TB] FAIL flush_timeout got no final segment want one");
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL missing_segments got %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/buzzer_scheduler.md
# buzzer_scheduler

Arbitrates and sequences all buzzer demands in the clock design: alarm time-up, hourly chime and key click. Runs tone on/off patterns on a half-second grid and drives the tone select and enable consumed by the tone generator. Sits between the timekeeping/alarm/keypad logic and the buzzer tone generator, which is the only block that drives the pin.

## Interface
- `HALF_CYCLES`, default 24'd12000000: CLK cycles per half-second phase (24 MHz).
- `KEY_CYCLES`, default 22'd2400000: key-click duration in cycles (100 ms).
- `ALARM_HALVES`, default 7'd60: maximum alarm length in half-second phases (30 s).
- `CLK` in 1: system clock.
- `RST` in 1: reset. Synchronous, active-high.
- `alarm_req` in 1: level; time-up condition from the alarm comparator.
- `alarm_ack` in 1: one-cycle pulse; user silences the alarm.
- `chime_req` in 1: one-cycle pulse at the top of the hour.
- `chime_count` in 4: number of chime beeps, sampled with `chime_req`.
- `key_req` in 1: one-cycle pulse on a key press.
- `tone_en` out 1: tone generator enable.
- `tone_sel` out 2: 0 = none, 1 = tick/chime, 2 = alarm, 3 = key.
- `busy` out 1: high in any state other than IDLE.
- `alarm_active` out 1: high in ALARM_ON or ALARM_OFF.

## Operation
- States: IDLE, KEY, CHIME_ON, CHIME_OFF, ALARM_ON, ALARM_OFF.
- Priority is alarm > chime > key.
- **Phase timer**
  - `ph_cnt` is cleared on every state entry and increments each cycle.
  - A phase ends when `ph_cnt == HALF_CYCLES-1`. KEY uses `KEY_CYCLES-1` instead.
- **Alarm**
  - Enters ALARM_ON from any state when `alarm_req` = 1 and `armed` = 1. This preempts KEY and CHIME immediately.
  - ON and OFF alternate every phase. `al_cnt` counts completed phases.
  - The alarm ends, returning to IDLE, on any of:
    - `alarm_ack` = 1,
    - `alarm_req` = 0,
    - `al_cnt == ALARM_HALVES-1` at the end of a phase.
  - Ending by ack or timeout clears `armed`. `armed` sets again only when `alarm_req` = 0. A held `alarm_req` therefore does not retrigger.
  - Ending because `alarm_req` fell leaves `armed` = 1.
- **Chime**
  - `chime_req` loads the pending latch: `pend` = 1 and `pend_n` = clamp(`chime_count`, 1..12). A count of 0 loads nothing.
  - A new `chime_req` while `pend` = 1 overwrites `pend_n`.
  - From IDLE with `pend` = 1, go to CHIME_ON, load `beep_left` from `pend_n`, and clear `pend`.
  - CHIME_ON goes to CHIME_OFF at the end of a phase.
  - CHIME_OFF goes to CHIME_ON with `beep_left` − 1 if the result is nonzero. Otherwise it goes to IDLE.
  - A chime preempted by the alarm is dropped. Only a `pend` latched during the alarm is served afterward.
- **Key**
  - `key_req` in IDLE with no `pend` and no armed `alarm_req` goes to KEY for `KEY_CYCLES`, then back to IDLE.
  - `key_req` in any other state is discarded.
  - A `chime_req` arriving during KEY latches `pend`. At the end of KEY the machine goes through IDLE for one cycle, then to CHIME_ON.
- **Outputs**
  - `tone_en` = 1 in KEY, CHIME_ON and ALARM_ON.
  - `tone_sel` is 3, 1 and 2 respectively, and 0 otherwise, including in the OFF states.
- **Simultaneous requests** in one cycle are resolved by priority: `alarm_req` wins, `chime_req` still latches `pend`, and `key_req` is dropped.

## Timing
- All outputs are registered from next-state and change on the same edge as the state.
- Latency: a request sampled at edge k shows in the outputs right after edge k.
- Durations:
  - ON and OFF phases are exactly `HALF_CYCLES` cycles each.
  - KEY is exactly `KEY_CYCLES` cycles.
  - Alarm ack takes effect at the next edge.
- Reset values:
  - state IDLE, `tone_en` 0, `tone_sel` 0, `busy` 0, `alarm_active` 0,
  - `armed` 1, `pend` 0, all counters 0.
- Reset asserted mid-pattern forces these values at the next edge. No pending work survives.
- Width rules:
  - `ph_cnt` is 24 bits and `al_cnt` is 7 bits. Both saturate-compare and never wrap inside a state.
  - `beep_left` is 4 bits.

## Configuration
- `BUZZER_SCHED_KEYCLICK_EN` defined: the KEY state and the key requester are compiled in, as described above.
- Undefined:
  - the KEY state is removed,
  - the `key_req` port remains but is ignored,
  - `tone_sel` never equals 3,
  - `KEY_CYCLES` is unused.

## Test plan
Bench parameters: `HALF_CYCLES`=10, `KEY_CYCLES`=4, `ALARM_HALVES`=6, `BUZZER_SCHED_KEYCLICK_EN` defined.
- Chime pulse with `chime_count`=3 in IDLE → `tone_sel` sequence 1,0,1,0,1,0, each 10 cycles, then IDLE. `busy` is high for exactly 60 cycles.
- `alarm_req` held high with no ack → ALARM_ON/OFF for 6 phases (60 cycles), then IDLE. `alarm_req` is still high but there is no retrigger until it drops and rises again.
- Chime with count 12 in progress, `alarm_req` at cycle 25 → `tone_sel`=2 from edge 26. After `alarm_ack` → IDLE and the chime is not resumed.
- Alarm active, `chime_req` with count 2, then `alarm_ack` → one IDLE cycle, then a 2-beep chime.
- `key_req` in IDLE → `tone_sel`=3 for 4 cycles. `key_req` during CHIME_ON → no effect. `chime_count`=0 → stays IDLE. `chime_count`=15 → 12 beeps.
- `RST` asserted in ALARM_ON with `pend`=1 → all outputs 0 at the next edge, then stays IDLE.
